line_buffer_win: RTL and testbench

Parametrised circular line buffer for the image-filter datapath. It stores one image line of `LINE_W` pixels and presents a `TAPS`-pixel horizontal window starting at the read column. It also tracks occupancy, flow-controls reads and writes, wraps at any line length, and optionally replicates the right-edge pixel. Several instances sit in parallel between the pixel source and the convolution engine, one per kernel row.

---
 rtl/line_buffer_pkg.sv | 23 ++
 rtl/lb_ram.sv | 33 +++
 rtl/line_buffer_win.sv | 142 ++++++++++++++
 tb/tb_line_buffer_win.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_pkg.sv
// Shared constants and helpers for the line_buffer_win circular line buffer.
package line_buffer_pkg;

    localparam int LB_DATA_W = 8;
    localparam int LB_LINE_W = 512;
    localparam int LB_TAPS   = 3;

    // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Increment with explicit wrap at 'limit'; used for both pointers and the column.
    function automatic int mod_inc(input int value, input int limit);
        return (value >= limit - 1) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/lb_ram.sv
// Line storage: LINE_W x DATA_W, one synchronous write port and TAPS
// combinational read ports that see the pre-edge contents.
module lb_ram #(
    parameter int DATA_W = 8,
    parameter int LINE_W = 512,
    parameter int TAPS   = 3,
    parameter int AW     = 9
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [AW-1:0]                    waddr,
    input  logic [DATA_W-1:0]                wdata,
    input  logic [TAPS-1:0][AW-1:0]          raddr,
    output logic [TAPS-1:0][DATA_W-1:0]      rdata
);

    // Contents are intentionally never cleared; occupancy is tracked by the caller.
    logic [DATA_W-1:0] mem [LINE_W];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Asynchronous read for every tap.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < TAPS; k++) begin
            rdata[k] = mem[raddr[k]];
        end
    end

endmodule

// File: rtl/line_buffer_win.sv
// Circular line buffer presenting a TAPS-pixel horizontal window at the read column.
// Optional feature: define LB_EDGE_REPLICATE_EN to replicate the last pixel of the
// line into taps that would otherwise run past column LINE_W-1.
//
// Handshake: a write is accepted when i_data_valid && (!o_full || read accepted);
// a read is accepted when i_rd_data && o_data_valid. Both take effect at the rising
// edge; requests that are not accepted have no effect except that a dropped write
// sets the sticky o_overflow flag.
module line_buffer_win
    import line_buffer_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int LINE_W = LB_LINE_W,
    parameter int TAPS   = LB_TAPS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_data_valid,
    input  logic                          i_rd_data,
    output logic [TAPS*DATA_W-1:0]        o_data,
    output logic                          o_data_valid,
    output logic [$clog2(LINE_W+1)-1:0]   o_count,
    output logic [$clog2(LINE_W)-1:0]     o_col,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_overflow
);

    localparam int AW = clog2(LINE_W);
    localparam int CW = clog2(LINE_W + 1);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] col_q, col_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          valid;
    logic          wr_accept;
    logic          rd_accept;
    logic [CW-1:0] need;

    logic [TAPS-1:0][AW-1:0]     tap_addr;
    logic [TAPS-1:0][DATA_W-1:0] tap_data;

    assign full      = (count_q == CW'(LINE_W));
    assign valid     = (count_q >= need);
    assign rd_accept = i_rd_data && valid;
    assign wr_accept = i_data_valid && (!full || rd_accept);

    // Pixels required before the window at the current column is readable.
    always_comb begin
        need = CW'(TAPS);
`ifdef LB_EDGE_REPLICATE_EN
        if ((LINE_W - int'(col_q)) < TAPS) need = CW'(LINE_W - int'(col_q));
`endif
    end

    // Next-state for pointers, column, occupancy and overflow flag.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        col_d   = col_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (wr_accept) wp_d = AW'(mod_inc(int'(wp_q), LINE_W));
        if (rd_accept) begin
            rp_d  = AW'(mod_inc(int'(rp_q), LINE_W));
            col_d = AW'(mod_inc(int'(col_q), LINE_W));
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (i_data_valid && full && !rd_accept) ovf_d = 1'b1;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            col_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            col_q   <= col_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Tap k reads (rp+k) mod LINE_W, or the last column of the line when replicating.
    always_comb begin
        int idx;
        idx      = 0;
        tap_addr = '0;
        for (int k = 0; k < TAPS; k++) begin
            idx = int'(rp_q) + k;
`ifdef LB_EDGE_REPLICATE_EN
            if (int'(col_q) + k > LINE_W - 1) idx = int'(rp_q) + LINE_W - 1 - int'(col_q);
`endif
            if (idx >= LINE_W) idx = idx - LINE_W;
            tap_addr[k] = AW'(idx);
        end
    end

    lb_ram #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W),
        .TAPS   (TAPS),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (wr_accept && reset),
        .waddr  (wp_q),
        .wdata  (i_data),
        .raddr  (tap_addr),
        .rdata  (tap_data)
    );

    // Pack taps with tap 0 in the most significant slot.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < TAPS; k++) begin
            o_data[(TAPS-1-k)*DATA_W +: DATA_W] = tap_data[k];
        end
    end

    assign o_data_valid = valid;
    assign o_count      = count_q;
    assign o_col        = col_q;
    assign o_full       = full;
    assign o_empty      = (count_q == '0);
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_line_buffer_win.sv
// Self-checking bench for line_buffer_win: a directed vector table on an
// 8-pixel line plus a streamed wrap sequence on a 5-pixel line.
// Expectations for the edge cases follow LB_EDGE_REPLICATE_EN.
module tb_line_buffer_win;

    logic clk;

    // 8-pixel instance
    logic        reset8, wr8, rd8;
    logic [7:0]  din8;
    logic [23:0] data8;
    logic        valid8, full8, empty8, ovf8;
    logic [3:0]  count8;
    logic [2:0]  col8;

    // 5-pixel instance
    logic        reset5, wr5, rd5;
    logic [7:0]  din5;
    logic [23:0] data5;
    logic        valid5, full5, empty5, ovf5;
    logic [2:0]  count5;
    logic [2:0]  col5;

    int n_cmp = 0;
    int n_bad = 0;

    line_buffer_win #(.DATA_W(8), .LINE_W(8), .TAPS(3)) dut8 (
        .clk(clk), .reset(reset8), .i_data(din8), .i_data_valid(wr8), .i_rd_data(rd8),
        .o_data(data8), .o_data_valid(valid8), .o_count(count8), .o_col(col8),
        .o_full(full8), .o_empty(empty8), .o_overflow(ovf8)
    );

    line_buffer_win #(.DATA_W(8), .LINE_W(5), .TAPS(3)) dut5 (
        .clk(clk), .reset(reset5), .i_data(din5), .i_data_valid(wr5), .i_rd_data(rd5),
        .o_data(data5), .o_data_valid(valid5), .o_count(count5), .o_col(col5),
        .o_full(full5), .o_empty(empty5), .o_overflow(ovf5)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [7:0]  din;
        logic        rd;
        logic [3:0]  e_count;
        logic [2:0]  e_col;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic        e_valid;
        logic        chk_data;
        logic [23:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic wr, input logic [7:0] din, input logic rd,
                       input logic [3:0] cnt, input logic [2:0] col, input logic ovf,
                       input logic vld, input logic chk, input logic [23:0] d);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.din = din; v.rd = rd;
        v.e_count = cnt; v.e_col = col; v.e_ovf = ovf; v.e_valid = vld;
        v.e_full = (cnt == 4'd8); v.e_empty = (cnt == 4'd0);
        v.chk_data = chk; v.e_data = d;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard state for the 5-pixel stream
    logic [7:0] exp_q[$];
    int m_count, m_col, m_need, n_wr, n_rd;
    logic m_valid;
    logic [23:0] m_data;

    task automatic model_eval();
        m_need = 3;
`ifdef LB_EDGE_REPLICATE_EN
        if (5 - m_col < 3) m_need = 5 - m_col;
`endif
        m_valid = (m_count >= m_need);
    endtask

    initial begin
        reset8 = 1'b0; wr8 = 1'b0; rd8 = 1'b0; din8 = '0;
        reset5 = 1'b0; wr5 = 1'b0; rd5 = 1'b0; din5 = '0;

        // ---------------- vector table, LINE_W = 8 ----------------
        // rst wr din rd | count col ovf valid chk data
        add(0, 1, 8'd99, 1, 0, 0, 0, 0, 0, 24'h0);       // requests ignored in reset
        add(1, 1, 8'd1,  0, 1, 0, 0, 0, 0, 24'h0);
        add(1, 1, 8'd2,  0, 2, 0, 0, 0, 0, 24'h0);
        add(1, 0, 8'd0,  1, 2, 0, 0, 0, 0, 24'h0);       // read underflow ignored
        add(1, 1, 8'd3,  0, 3, 0, 0, 1, 1, 24'h010203);
        add(1, 0, 8'd0,  1, 2, 1, 0, 0, 0, 24'h0);
        add(1, 1, 8'd4,  0, 3, 1, 0, 1, 1, 24'h020304);
        for (int i = 0; i < 5; i++)                      // 5..9, wp wraps at 8
            add(1, 1, 8'(5 + i), 0, 4'(4 + i), 1, 0, 1, 1, 24'h020304);
        add(1, 1, 8'd10, 0, 8, 1, 1, 1, 1, 24'h020304);  // dropped, overflow
        add(1, 1, 8'd10, 1, 8, 2, 1, 1, 1, 24'h030405);  // accepted with read
        add(1, 0, 8'd0,  1, 7, 3, 1, 1, 1, 24'h040506);
        add(1, 0, 8'd0,  1, 6, 4, 1, 1, 1, 24'h050607);
        add(1, 0, 8'd0,  1, 5, 5, 1, 1, 1, 24'h060708);
        add(0, 1, 8'd55, 1, 0, 0, 0, 0, 0, 24'h0);       // reset mid-stream
        for (int i = 0; i < 8; i++)                      // line 10..17
            add(1, 1, 8'(10 + i), 0, 4'(i + 1), 0, 0, i >= 2, i >= 2, 24'h0a0b0c);
        for (int r = 1; r <= 5; r++)
            add(1, 0, 8'd0, 1, 4'(8 - r), 3'(r), 0, 1, 1, {8'(10 + r), 8'(11 + r), 8'(12 + r)});
`ifdef LB_EDGE_REPLICATE_EN
        add(1, 0, 8'd0, 1, 2, 6, 0, 1, 1, 24'h101111);
        add(1, 0, 8'd0, 1, 1, 7, 0, 1, 1, 24'h111111);
`else
        add(1, 0, 8'd0, 1, 2, 6, 0, 0, 0, 24'h0);
        add(1, 0, 8'd0, 1, 2, 6, 0, 0, 0, 24'h0);        // read ignored, window incomplete
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset8 = vecs[i].rst_n; wr8 = vecs[i].wr; din8 = vecs[i].din; rd8 = vecs[i].rd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), 32'(count8), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_col", i),   32'(col8),   32'(vecs[i].e_col));
            chk($sformatf("v%0d_full", i),  32'(full8),  32'(vecs[i].e_full));
            chk($sformatf("v%0d_empty", i), 32'(empty8), 32'(vecs[i].e_empty));
            chk($sformatf("v%0d_ovf", i),   32'(ovf8),   32'(vecs[i].e_ovf));
            chk($sformatf("v%0d_valid", i), 32'(valid8), 32'(vecs[i].e_valid));
            if (vecs[i].chk_data)
                chk($sformatf("v%0d_data", i), 32'(data8), 32'(vecs[i].e_data));
        end
        @(negedge clk);
        wr8 = 1'b0; rd8 = 1'b0;

        // ---------------- stream wrap, LINE_W = 5 ----------------
        reset5 = 1'b0;
        @(posedge clk);
        #1;
        chk("w5_reset_empty", 32'(empty5), 32'd1);
        chk("w5_reset_count", 32'(count5), 32'd0);
        m_count = 0; m_col = 0; n_wr = 0; n_rd = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            reset5 = 1'b1;
            model_eval();
            rd5  = m_valid && (((cyc % 3) != 0) || m_count == 5);
            wr5  = (n_wr < 12) && (m_count < 5 || rd5);
            din5 = 8'(8'h40 + n_wr);
            @(posedge clk);
            #1;
            if (rd5) begin
                void'(exp_q.pop_front());
                m_col = (m_col == 4) ? 0 : m_col + 1;
                n_rd++;
            end
            if (wr5) begin
                exp_q.push_back(din5);
                n_wr++;
            end
            m_count = exp_q.size();
            model_eval();
            chk($sformatf("w5_c%0d_count", cyc), 32'(count5), 32'(m_count));
            chk($sformatf("w5_c%0d_col", cyc),   32'(col5),   32'(m_col));
            chk($sformatf("w5_c%0d_valid", cyc), 32'(valid5), 32'(m_valid));
            if (m_valid) begin
                m_data = '0;
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = k;
`ifdef LB_EDGE_REPLICATE_EN
                    if (m_col + k > 4) idx = 4 - m_col;
`endif
                    m_data = {m_data[15:0], exp_q[idx]};
                end
                chk($sformatf("w5_c%0d_data", cyc), 32'(data5), 32'(m_data));
            end
            chk($sformatf("w5_c%0d_ovf", cyc), 32'(ovf5), 32'd0);
        end
        @(negedge clk);
        wr5 = 1'b0; rd5 = 1'b0;
        chk("w5_all_written", 32'(n_wr), 32'd12);
        chk("w5_reads_wrapped", 32'(n_rd >= 10), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
